// File: rtl/cacheline_adaptor_pkg.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor_pkg
// Shared definitions for the cache-line <-> burst-memory adaptor:
//   - state_t       : adaptor FSM states
//   - LINE_W_DEF    : default cache line width in bits
//   - BURST_W_DEF   : default burst beat width in bits
//   - LINE_OFFSET_W : number of byte-offset bits inside one cache line
// -----------------------------------------------------------------------------
package cacheline_adaptor_pkg;

   localparam int LINE_W_DEF    = 256;
   localparam int BURST_W_DEF   = 64;
   localparam int LINE_OFFSET_W = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      DONE     = 2'd3
   } state_t;

endpackage

// File: rtl/cacheline_adaptor_beat_buffer.sv
// -----------------------------------------------------------------------------
// cla_beat_buffer
// Beat counter plus shift-in line buffer for the cacheline adaptor.
// The counter selects which BURST_W slice of the line the current beat maps
// to; during reads the incoming beat is written into that slice.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : hold the beat counter at zero (adaptor not bursting)
//   beat       : one accepted/delivered beat this cycle, advance the counter
//   load       : write burst_in into the buffer slice selected by count
//   burst_in   : beat data from burst memory
//   count      : current beat index
//   line       : assembled read line
// -----------------------------------------------------------------------------
module cla_beat_buffer #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int CNT_W   = $clog2(LINE_W / BURST_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               beat,
   input  logic               load,
   input  logic [BURST_W-1:0] burst_in,
   output logic [CNT_W-1:0]   count,
   output logic [LINE_W-1:0]  line
);

   // The buffer is never cleared between reads, so the previous read line
   // stays visible until the first beat of the next read overwrites slice 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         line  <= '0;
      end else begin
         if (clear) begin
            count <= '0;
         end else if (beat) begin
            count <= count + 1'b1;
         end
         if (load) begin
            line[count*BURST_W +: BURST_W] <= burst_in;
         end
      end
   end

endmodule

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
// Bridges a cache that moves whole LINE_W-bit lines to a burst memory that
// moves BURST_W-bit beats. A read collects LINE_W/BURST_W beats into a line;
// a write latches the line and streams it out beat 0 first.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   line_i / line_o      : write line from cache / read line to cache
//   address_i            : cache byte address
//   read_i / write_i     : cache requests, held until resp_o
//   resp_o               : one-cycle completion pulse to cache
//   burst_i / burst_o    : read beat from memory / write beat to memory
//   address_o            : line-aligned memory address (low 5 bits zero)
//   read_o / write_o     : memory burst requests
//   resp_i               : memory beat strobe
//   err_o                : sticky protocol error flag, only present when
//                          CACHELINE_ADAPTOR_ERR_EN is defined
// -----------------------------------------------------------------------------
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
#(
   parameter int LINE_W  = LINE_W_DEF,
   parameter int BURST_W = BURST_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
`ifdef CACHELINE_ADAPTOR_ERR_EN
   ,
   output logic               err_o
`endif
);

   localparam int BEATS  = LINE_W / BURST_W;
   localparam int CNT_W  = $clog2(BEATS);
   localparam int LADR_W = 32 - LINE_OFFSET_W;

   state_t              state;
   state_t              state_next;
   logic [LADR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   wline_q;
   logic [CNT_W-1:0]    count;
   logic                bursting;
   logic                last_beat;
   logic                addr_unused;

   assign bursting  = (state == RD_BURST) || (state == WR_BURST);
   assign last_beat = (count == CNT_W'(BEATS - 1));

   // The byte offset inside a line never reaches memory.
   assign addr_unused = ^address_i[LINE_OFFSET_W-1:0];

   cla_beat_buffer #(
      .LINE_W  (LINE_W),
      .BURST_W (BURST_W),
      .CNT_W   (CNT_W)
   ) u_beat_buffer (
      .clk      (clk),
      .rst      (rst),
      .clear    (!bursting),
      .beat     (bursting && resp_i),
      .load     ((state == RD_BURST) && resp_i),
      .burst_in (burst_i),
      .count    (count),
      .line     (line_o)
   );

   // State register plus the request latches. Requests are only sampled in
   // IDLE, so anything the cache does mid-transaction is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wline_q <= '0;
      end else begin
         state <= state_next;
         if ((state == IDLE) && (read_i || write_i)) begin
            addr_q <= address_i[31:LINE_OFFSET_W];
         end
         if ((state == IDLE) && !read_i && write_i) begin
            wline_q <= line_i;
         end
      end
   end

   // Next-state logic. Read wins over a simultaneous write; DONE always
   // returns to IDLE so the cache has a cycle to drop its request.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (read_i) begin
               state_next = RD_BURST;
            end else if (write_i) begin
               state_next = WR_BURST;
            end
         end
         RD_BURST, WR_BURST: begin
            if (resp_i && last_beat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decoded straight from state; the write beat is muxed out of the
   // latched line so memory sees the new beat as soon as the counter moves.
   always_comb begin
      read_o    = (state == RD_BURST);
      write_o   = (state == WR_BURST);
      resp_o    = (state == DONE);
      address_o = {addr_q, {LINE_OFFSET_W{1'b0}}};
      burst_o   = '0;
      if (state == WR_BURST) begin
         burst_o = wline_q[count*BURST_W +: BURST_W];
      end
   end

`ifdef CACHELINE_ADAPTOR_ERR_EN
   logic [31:0] addr_prev;

   // Sticky error: conflicting requests in IDLE, or the cache moving its
   // address while a burst for the old address is still running.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_o     <= 1'b0;
         addr_prev <= '0;
      end else begin
         addr_prev <= address_i;
         if ((state == IDLE) && read_i && write_i) begin
            err_o <= 1'b1;
         end
         if (bursting && (address_i != addr_prev)) begin
            err_o <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
// Directed bench for cacheline_adaptor: reset, line read, line write,
// read/write collision, reset mid-burst, stray memory strobes with a long
// first-beat delay, and back-to-back transactions.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;
`ifdef CACHELINE_ADAPTOR_ERR_EN
   logic         err_o;
`endif

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int resp_pulses = 0;

   cacheline_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
`ifdef CACHELINE_ADAPTOR_ERR_EN
      ,
      .err_o     (err_o)
`endif
   );

   always #5 clk = ~clk;

   // Free-running edge counter used for latency measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // Counts completion pulses, sampled mid-cycle.
   always @(negedge clk) if (resp_o === 1'b1) resp_pulses <= resp_pulses + 1;

   // Full read: waits for read_o, idles lat cycles, feeds four beats, and
   // returns in the DONE cycle with read_i already dropped.
   task automatic read_txn(input logic [31:0] addr, input int lat,
                           input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3,
                           input string name);
      logic [63:0]  beats [4];
      logic [255:0] exp_line;
      logic [31:0]  exp_addr;
      int rise;
      int n;
      beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
      exp_line = {b3, b2, b1, b0};
      exp_addr = {addr[31:5], 5'b0};
      read_i = 1'b1;
      address_i = addr;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (read_o !== 1'b1 && n < 8);
      checks++;
      if (read_o !== 1'b1) $display("[TB] FAIL %s read_o start: got %b required 1", name, read_o);
      else passes++;
      rise = cyc;
      checks++;
      if (address_o !== exp_addr) $display("[TB] FAIL %s address_o: got %h required %h", name, address_o, exp_addr);
      else passes++;
      repeat (lat) begin @(posedge clk); #1; end
      for (int k = 0; k < 4; k++) begin
         resp_i = 1'b1;
         burst_i = beats[k];
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
      burst_i = '0;
      checks++;
      if (resp_o !== 1'b1) $display("[TB] FAIL %s resp_o: got %b required 1", name, resp_o);
      else passes++;
      checks++;
      if (cyc - rise !== lat + 4) $display("[TB] FAIL %s latency: got %0d required %0d", name, cyc - rise, lat + 4);
      else passes++;
      checks++;
      if (read_o !== 1'b0) $display("[TB] FAIL %s read_o in done: got %b required 0", name, read_o);
      else passes++;
      checks++;
      if (line_o !== exp_line) $display("[TB] FAIL %s line_o: got %h required %h", name, line_o, exp_line);
      else passes++;
      read_i = 1'b0;
   endtask

   // Full write: waits for write_o, checks every beat presented on burst_o,
   // and returns in the DONE cycle with write_i already dropped.
   task automatic write_txn(input logic [31:0] addr, input int lat,
                            input logic [255:0] line, input string name);
      logic [31:0] exp_addr;
      int n;
      int wcyc;
      exp_addr = {addr[31:5], 5'b0};
      write_i = 1'b1;
      line_i = line;
      address_i = addr;
      n = 0;
      wcyc = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (write_o !== 1'b1 && n < 8);
      checks++;
      if (write_o !== 1'b1) $display("[TB] FAIL %s write_o start: got %b required 1", name, write_o);
      else passes++;
      checks++;
      if (address_o !== exp_addr) $display("[TB] FAIL %s address_o: got %h required %h", name, address_o, exp_addr);
      else passes++;
      for (int j = 0; j < lat; j++) begin
         if (write_o === 1'b1) wcyc++;
         @(posedge clk); #1;
      end
      for (int k = 0; k < 4; k++) begin
         if (write_o === 1'b1) wcyc++;
         resp_i = 1'b1;
         checks++;
         if (burst_o !== line[k*64 +: 64]) $display("[TB] FAIL %s burst_o beat %0d: got %h required %h", name, k, burst_o, line[k*64 +: 64]);
         else passes++;
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
      checks++;
      if (resp_o !== 1'b1) $display("[TB] FAIL %s resp_o: got %b required 1", name, resp_o);
      else passes++;
      checks++;
      if (wcyc !== lat + 4) $display("[TB] FAIL %s write_o cycles: got %0d required %0d", name, wcyc, lat + 4);
      else passes++;
      checks++;
      if (write_o !== 1'b0 || burst_o !== 64'h0) $display("[TB] FAIL %s write idle in done: got write_o=%b burst_o=%h required 0/0", name, write_o, burst_o);
      else passes++;
      write_i = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      line_i = '0; address_i = '0; burst_i = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) $display("[TB] FAIL reset strobes: got r=%b w=%b resp=%b required 0", read_o, write_o, resp_o);
      else passes++;
      checks++;
      if (address_o !== 32'h0) $display("[TB] FAIL reset address_o: got %h required 0", address_o);
      else passes++;
      checks++;
      if (line_o !== 256'h0) $display("[TB] FAIL reset line_o: got %h required 0", line_o);
      else passes++;
      checks++;
      if (burst_o !== 64'h0) $display("[TB] FAIL reset burst_o: got %h required 0", burst_o);
      else passes++;
`ifdef CACHELINE_ADAPTOR_ERR_EN
      checks++;
      if (err_o !== 1'b0) $display("[TB] FAIL reset err_o: got %b required 0", err_o);
      else passes++;
`endif
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_read;
      int p0;
      p0 = resp_pulses;
      read_txn(32'h0000_1234, 2, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, "read");
      @(posedge clk); #1;
      checks++;
      if (resp_o !== 1'b0) $display("[TB] FAIL read resp_o width: got %b required 0", resp_o);
      else passes++;
      checks++;
      if (resp_pulses - p0 !== 1) $display("[TB] FAIL read pulse count: got %0d required 1", resp_pulses - p0);
      else passes++;
      checks++;
      if (line_o !== {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}) $display("[TB] FAIL read line_o hold: got %h", line_o);
      else passes++;
   endtask

   task automatic test_write;
      int p0;
      p0 = resp_pulses;
      write_txn(32'h0000_0040, 3, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, "write");
      @(posedge clk); #1;
      checks++;
      if (resp_pulses - p0 !== 1) $display("[TB] FAIL write pulse count: got %0d required 1", resp_pulses - p0);
      else passes++;
   endtask

   task automatic test_read_write_collision;
      write_i = 1'b1;
      line_i = {4{64'hBAD0_BAD0_BAD0_BAD0}};
      read_txn(32'h0000_0080, 1, 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
               64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404, "collision");
      write_i = 1'b0;
`ifdef CACHELINE_ADAPTOR_ERR_EN
      checks++;
      if (err_o !== 1'b1) $display("[TB] FAIL collision err_o: got %b required 1", err_o);
      else passes++;
`endif
      @(posedge clk); #1;
      checks++;
      if (write_o !== 1'b0) $display("[TB] FAIL collision write_o: got %b required 0", write_o);
      else passes++;
   endtask

   task automatic test_reset_mid_read;
      int p0;
      p0 = resp_pulses;
      read_i = 1'b1;
      address_i = 32'h0000_0200;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         resp_i = 1'b1;
         burst_i = 64'hE0E0_0000_0000_0000 + 64'(k);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      burst_i = 64'hE0E0_0000_0000_0003;
      @(posedge clk); #1;
      rst = 1'b0;
      read_i = 1'b0;
      checks++;
      if (read_o !== 1'b0 || resp_o !== 1'b0) $display("[TB] FAIL midreset strobes: got r=%b resp=%b required 0", read_o, resp_o);
      else passes++;
      checks++;
      if (address_o !== 32'h0 || line_o !== 256'h0) $display("[TB] FAIL midreset clear: got addr=%h line=%h required 0", address_o, line_o);
      else passes++;
      repeat (2) begin @(posedge clk); #1; end
      resp_i = 1'b0;
      burst_i = '0;
      checks++;
      if (line_o !== 256'h0 || resp_pulses - p0 !== 0) $display("[TB] FAIL midreset leftover beats: got line=%h pulses=%0d required 0/0", line_o, resp_pulses - p0);
      else passes++;
      read_txn(32'h0000_0100, 1, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
               64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, "after_reset");
      @(posedge clk); #1;
   endtask

   task automatic test_stray_resp;
      logic [255:0] held;
      held = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
              64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
      burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) begin
         resp_i = 1'b1;
         @(posedge clk); #1;
         resp_i = 1'b0;
         @(posedge clk); #1;
      end
      burst_i = '0;
      checks++;
      if (line_o !== held) $display("[TB] FAIL stray line_o: got %h required %h", line_o, held);
      else passes++;
      checks++;
      if (resp_o !== 1'b0 || read_o !== 1'b0) $display("[TB] FAIL stray strobes: got resp=%b r=%b required 0", resp_o, read_o);
      else passes++;
      read_txn(32'h0000_03C0, 10, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
               64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, "long_latency");
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int p0;
      logic [255:0] wl;
      p0 = resp_pulses;
      wl = {64'hF00D_0000_0000_0004, 64'hF00D_0000_0000_0003,
            64'hF00D_0000_0000_0002, 64'hF00D_0000_0000_0001};
      read_txn(32'h0000_0500, 1, 64'hC001_0000_0000_0000, 64'hC002_0000_0000_0000,
               64'hC003_0000_0000_0000, 64'hC004_0000_0000_0000, "b2b_read");
      write_i = 1'b1;
      line_i = wl;
      address_i = 32'h0000_0540;
      @(posedge clk); #1;
      checks++;
      if (resp_o !== 1'b0 || write_o !== 1'b0 || read_o !== 1'b0) $display("[TB] FAIL b2b idle gap: got resp=%b w=%b r=%b required 0", resp_o, write_o, read_o);
      else passes++;
      write_txn(32'h0000_0540, 0, wl, "b2b_write");
      @(posedge clk); #1;
      checks++;
      if (resp_pulses - p0 !== 2) $display("[TB] FAIL b2b pulse count: got %0d required 2", resp_pulses - p0);
      else passes++;
      checks++;
      if (line_o !== {64'hC004_0000_0000_0000, 64'hC003_0000_0000_0000, 64'hC002_0000_0000_0000, 64'hC001_0000_0000_0000}) $display("[TB] FAIL b2b line_o after write: got %h", line_o);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_read_write_collision();
      test_reset_mid_read();
      test_stray_resp();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
